// File: rtl/gsu_mem_arbiter.sv
// gsu_mem_arbiter
// Shares the single cartridge ROM/RAM bus between the SNES CPU and the two GSU
// requesters (instruction fetch, load/store data). Applies the SCMR RON/RAN
// ownership bits at grant time and runs fixed-length memory cycles.
//
// Ports
//   mck, reset                 master clock, async active-high reset
//   ron, ran                   GSU owns ROM / RAM
//   snes_* (req/we/addr/wdata) SNES slot request, snes_ack/snes_rdata back
//   fet_*  (req/addr)          GSU fetch request, fet_ack/fet_rdata back
//   dat_*  (req/we/addr/wdata) GSU data request, dat_ack/dat_rdata back
//   mem_addr/mem_wdata/mem_rd/mem_wr out, mem_rdata in: external bus
//   perf_fet_stall             fetch stall counter (only with ARB_PERF_EN)
//
// Build option: define ARB_PERF_EN to add the perf_fet_stall counter/port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | arbitrate; latch winner's address/data/direction
// S_ACCESS | strobe the bus for WAIT_CYC cycles, sample rdata on last
// S_DONE   | one-cycle ack to the owning port
module gsu_mem_arbiter #(
   parameter int unsigned WAIT_CYC   = 3,
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [7:0]  BLOCK_DATA = 8'h00
) (
   input  logic        mck,
   input  logic        reset,
   input  logic        ron,
   input  logic        ran,
   input  logic        snes_req,
   input  logic        snes_we,
   input  logic [23:0] snes_addr,
   input  logic [7:0]  snes_wdata,
   output logic        snes_ack,
   output logic [7:0]  snes_rdata,
   input  logic        fet_req,
   input  logic [23:0] fet_addr,
   output logic        fet_ack,
   output logic [7:0]  fet_rdata,
   input  logic        dat_req,
   input  logic        dat_we,
   input  logic [23:0] dat_addr,
   input  logic [7:0]  dat_wdata,
   output logic        dat_ack,
   output logic [7:0]  dat_rdata,
   output logic [23:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_rd,
   output logic        mem_wr
`ifdef ARB_PERF_EN
   ,
   output logic [15:0] perf_fet_stall
`endif
);

   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_LOAD   = CW'(WAIT_CYC - 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [1:0] {P_NONE, P_SNES, P_DAT, P_FET} port_t;

   state_t        state_q, state_d;
   port_t         port_q, port_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          we_q, we_d;
   logic          strobe_q, strobe_d;
   logic [23:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    snes_rdata_q, snes_rdata_d;
   logic [7:0]    fet_rdata_q, fet_rdata_d;
   logic [7:0]    dat_rdata_q, dat_rdata_d;

   logic dat_ok, fet_ok, fet_wins, snes_blocked;

   function automatic logic is_ram(input logic [23:0] a);
      return (a[23:16] == 8'h70) || (a[23:16] == 8'h71);
   endfunction

   function automatic logic gsu_owns(input logic [23:0] a, input logic ron_i, input logic ran_i);
      return is_ram(a) ? ran_i : ron_i;
   endfunction

   assign dat_ok       = dat_req && gsu_owns(dat_addr, ron, ran);
   assign fet_ok       = fet_req && gsu_owns(fet_addr, ron, ran);
   assign fet_wins     = fet_ok && (!dat_ok || (starve_q == STARVE_LIM));
   assign snes_blocked = gsu_owns(snes_addr, ron, ran);

   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      cnt_d        = cnt_q;
      starve_d     = starve_q;
      we_d         = we_q;
      strobe_d     = strobe_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      snes_rdata_d = snes_rdata_q;
      fet_rdata_d  = fet_rdata_q;
      dat_rdata_d  = dat_rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (snes_req) begin
               state_d  = S_ACCESS;
               port_d   = P_SNES;
               addr_d   = snes_addr;
               wdata_d  = snes_wdata;
               we_d     = snes_we;
               // A blocked SNES access spends a single strobe-less cycle in
               // ACCESS so its ack lands two cycles after the grant.
               strobe_d = !snes_blocked;
               cnt_d    = snes_blocked ? '0 : CNT_LOAD;
            end else if (fet_wins) begin
               state_d  = S_ACCESS;
               port_d   = P_FET;
               addr_d   = fet_addr;
               we_d     = 1'b0;
               strobe_d = 1'b1;
               cnt_d    = CNT_LOAD;
               starve_d = '0;
            end else if (dat_ok) begin
               state_d  = S_ACCESS;
               port_d   = P_DAT;
               addr_d   = dat_addr;
               wdata_d  = dat_wdata;
               we_d     = dat_we;
               // Stores into ROM run the full sequence but never pulse mem_wr.
               strobe_d = !(dat_we && !is_ram(dat_addr));
               cnt_d    = CNT_LOAD;
               if (fet_req && (starve_q != STARVE_LIM)) begin
                  starve_d = starve_q + SW'(1);
               end
            end
         end

         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!we_q) begin
                  unique case (port_q)
                     P_SNES:  snes_rdata_d = strobe_q ? mem_rdata : BLOCK_DATA;
                     P_FET:   fet_rdata_d  = mem_rdata;
                     P_DAT:   dat_rdata_d  = mem_rdata;
                     default: ;
                  endcase
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge mck or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         port_q       <= P_NONE;
         cnt_q        <= '0;
         starve_q     <= '0;
         we_q         <= 1'b0;
         strobe_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         snes_rdata_q <= '0;
         fet_rdata_q  <= '0;
         dat_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         port_q       <= port_d;
         cnt_q        <= cnt_d;
         starve_q     <= starve_d;
         we_q         <= we_d;
         strobe_q     <= strobe_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         snes_rdata_q <= snes_rdata_d;
         fet_rdata_q  <= fet_rdata_d;
         dat_rdata_q  <= dat_rdata_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_rd     = (state_q == S_ACCESS) && strobe_q && !we_q;
   assign mem_wr     = (state_q == S_ACCESS) && strobe_q && we_q;
   assign snes_ack   = (state_q == S_DONE) && (port_q == P_SNES);
   assign fet_ack    = (state_q == S_DONE) && (port_q == P_FET);
   assign dat_ack    = (state_q == S_DONE) && (port_q == P_DAT);
   assign snes_rdata = snes_rdata_q;
   assign fet_rdata  = fet_rdata_q;
   assign dat_rdata  = dat_rdata_q;

`ifdef ARB_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (fet_req && !fet_ack && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge mck or posedge reset) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_fet_stall = perf_q;
`endif

endmodule
